// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in clk cycles.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample hold
// filter after the synchronizer (pulses shorter than 3 cycles are dropped,
// both edges delayed equally so measurements are unchanged).
//
// Output handshake: valid is a one-cycle strobe with no ready/back-pressure.
// period_out/high_out/overflow change only in the cycle valid is high and
// hold otherwise; a consumer that misses the strobe reads the previous result.
module pwm_capture #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pwmin,
  output logic [CW-1:0] period_out,
  output logic [CW-1:0] high_out,
  output logic          valid,
  output logic          overflow,
  output logic          timeout,
  output logic          level,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic s1, s2, s, s_d;
  logic rise, fall;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1, h2;

  // Synchronize, then let s follow only after 3 equal synchronized samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      h1  <= 1'b0;
      h2  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= pwmin;
      s2  <= s1;
      h1  <= s2;
      h2  <= h1;
      if ((s2 == h1) && (h1 == h2)) s <= s2;
      s_d <= s;
    end
  end
`else
  // Synchronize, then register for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= pwmin;
      s2  <= s1;
      s   <= s2;
      s_d <= s;
    end
  end
`endif

  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign level = s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt, hcnt, cnt_inc;
  logic          ovf;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: disable always wins, otherwise walk the edges.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating increment of the live counter.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_MAX) cnt_inc = cnt + CNT_ONE;
  end

  // Counters, overflow flag and published results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      hcnt       <= '0;
      ovf        <= 1'b0;
      valid      <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      overflow   <= 1'b0;
    end else if (!enable || state_q == IDLE) begin
      cnt   <= '0;
      hcnt  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        ARM: begin
          if (rise) cnt <= CNT_ONE;
        end
        HIGH: begin
          cnt <= cnt_inc;
          if (cnt_inc == CNT_MAX) ovf <= 1'b1;
          if (fall) hcnt <= cnt;
        end
        LOW: begin
          if (rise) begin
            period_out <= cnt;
            high_out   <= hcnt;
            overflow   <= ovf;
            valid      <= 1'b1;
            ovf        <= 1'b0;
            cnt        <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout   = ((state_q == HIGH) || (state_q == LOW)) && (cnt == CNT_MAX);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus checked against an edge-time model.
module tb_pwm_capture;
  localparam int CW   = 8;
  localparam int MAXV = 255;
  localparam int HMAX = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          pwmin = 1'b0;
  logic [CW-1:0] period_out, high_out;
  logic          valid, overflow, timeout, level;
  logic [1:0]    state_dbg;

  pwm_capture #(.CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwmin      (pwmin),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .overflow   (overflow),
    .timeout    (timeout),
    .level      (level),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Reference model: works on the sampled input history and edge times.
  bit   p_h [HMAX];
  bit   e_h [HMAX];
  int   cyc = 8;
  bit   m_on, have_r;
  int   pr, pf;
  bit   x_valid, x_timeout, x_ovf;
  int   x_period, x_high;
  bit   rise_ev, fall_ev;
  logic [2*CW:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", cyc, HMAX);
      $fatal(1);
    end
    if (!rst) begin
      p_h[cyc] = 1'b0;
      e_h[cyc] = 1'b0;
      m_on = 0; have_r = 0; x_valid = 0;
      x_period = 0; x_high = 0; x_ovf = 0;
      exp_q.delete();
    end else begin
      p_h[cyc] = pwmin;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      e_h[cyc] = (p_h[cyc] == p_h[cyc-1] && p_h[cyc-1] == p_h[cyc-2]) ? p_h[cyc] : e_h[cyc-1];
`else
      e_h[cyc] = p_h[cyc];
`endif
      rise_ev = e_h[cyc-3] && !e_h[cyc-4];
      fall_ev = !e_h[cyc-3] && e_h[cyc-4];
      x_valid = 0;
      if (!enable) begin
        m_on = 0; have_r = 0;
      end else if (!m_on) begin
        m_on = 1;
      end else if (rise_ev) begin
        if (have_r) begin
          x_period = sat(cyc - pr);
          x_high   = sat(pf - pr);
          x_ovf    = (cyc - pr) >= MAXV;
          x_valid  = 1;
          exp_q.push_back({x_ovf, CW'(x_high), CW'(x_period)});
        end
        have_r = 1;
        pr = cyc;
      end else if (fall_ev && have_r) begin
        pf = cyc;
      end
    end
    x_timeout = have_r && ((cyc - pr) >= MAXV - 1);
  end

  // Scoreboard / monitor on the falling edge.
  logic [2*CW:0] sb_e;
  always @(negedge clk) begin
    if (rst) begin
      check_eq("valid", valid, x_valid);
      check_eq("timeout", timeout, x_timeout);
      check_eq("level", level, e_h[cyc-2]);
      check_eq("period_hold", period_out, x_period);
      check_eq("high_hold", high_out, x_high);
      check_eq("overflow_hold", overflow, x_ovf);
      if (valid) begin
        check_eq("sb_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check_eq("sb_result", int'({overflow, high_out, period_out}), int'(sb_e));
        end
      end
    end
  end

  // Driver tasks.
  task automatic drive_phase(input bit v, input int n);
    pwmin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_wave(input int h, input int l, input int n);
    repeat (n) begin
      drive_phase(1'b1, h);
      drive_phase(1'b0, l);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_period"}, period_out, 0);
    check_eq({tag, "_high"}, high_out, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_level"}, level, 0);
  endtask

  initial begin
    int h, l;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Synchronous 3 high / 5 low.
    drive_wave(3, 5, 6);
    drive_phase(1'b0, 12);

    // Random waveforms.
    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 12);
      drive_wave(h, l, $urandom_range(2, 4));
    end
    drive_phase(1'b0, 12);

    // Held high: timeout with level=1, then saturated period.
    drive_phase(1'b1, 300);
    check_eq("timeout_high", timeout, 1);
    check_eq("timeout_level", level, 1);
    drive_phase(1'b0, 20);

    // Long period 300 (high 100) then normal 10/4.
    drive_wave(100, 200, 1);
    drive_wave(10, 4, 3);
    drive_phase(1'b0, 12);

    // Enable dropped mid-period and re-raised.
    drive_wave(6, 6, 2);
    drive_phase(1'b1, 3);
    enable = 1'b0;
    pwmin  = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    drive_wave(5, 7, 3);
    drive_phase(1'b0, 12);

    // Asynchronous reset while in HIGH.
    drive_wave(4, 4, 2);
    pwmin = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_state", state_dbg, 2);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drive_wave(4, 4, 3);
    drive_phase(1'b0, 12);

    // 8/8 waveform with a 1-cycle low glitch inside the high phase.
    repeat (4) begin
      drive_phase(1'b1, 3);
      drive_phase(1'b0, 1);
      drive_phase(1'b1, 4);
      drive_phase(1'b0, 8);
    end
    drive_wave(8, 8, 2);
    drive_phase(1'b0, 15);

    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
